commit_unit: RTL
================

COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 SHALL have parameter RP, default 4, meaning physical copies per architectural register.
REQ-002 SHALL have parameter RB, default 2, meaning copy-index width, log2(RP).
REQ-003 SHALL have parameter DP, default 8, meaning reorder-queue depth, power of two, at least 2.
REQ-004 SHALL have port CLK  input  1  single clock, rising edge.
REQ-005 SHALL have port RSTn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush  input  1  pipeline flush request.
REQ-007 SHALL have port push_valid  input  1  rename stage offers one renamed instruction.
REQ-008 SHALL have port push_ready  output  1  queue can accept an entry.
REQ-009 SHALL have port push_rd  input  5  architectural destination register.
REQ-010 SHALL have port push_phy  input  RB  copy index allocated by rename.
REQ-011 SHALL have port wbLog_qout  input  32*RP  write-back-done bits; bit RP*X+c is register X, copy c.
REQ-012 SHALL have port archi_X_qout  input  RB*32  committed copy pointer per register.
REQ-013 SHALL have port archi_X_dnxt  output  RB*32  next committed copy pointers.
REQ-014 SHALL have port rnBufU_commit_rst  output  32*RP  one-cycle release of rename-buffer bits.
REQ-015 SHALL have port wbLog_commit_rst  output  32*RP  one-cycle release of write-back bits.
REQ-016 SHALL have port commit_valid  output  1  one instruction retires this cycle.
REQ-017 SHALL have port retire_cnt  output  64  count of retired instructions.

Function
REQ-018 SHALL hold entries {rd, phy} in a DP-entry circular FIFO with read and write pointers one bit wider than log2(DP).
- Empty: pointers equal.
- Full: indices equal and wrap bits differ.
REQ-019 SHALL drive push_ready = not full and not flush, combinationally.
REQ-020 SHALL write an entry when push_valid and push_ready are both high.
- The write pointer SHALL advance by 1 and wrap modulo 2*DP.
REQ-021 SHALL judge the head entry {rd=X, phy=p} ready when the FIFO is not empty and one of these holds:
- wbLog_qout[RP*X+p] is 1, or
- X is 0.
REQ-022 When the head is ready and flush is low, SHALL in the same cycle assert commit_valid and advance the read pointer by 1.
REQ-023 On a ready head with X != 0 and old pointer q = archi_X_qout[RB*X +: RB]:
- archi_X_dnxt field X = p.
- rnBufU_commit_rst bit RP*X+q = 1.
- wbLog_commit_rst bit RP*X+q = 1.
REQ-024 On a ready head with X = 0: SHALL retire without changing archi_X_dnxt and with both reset vectors zero.
REQ-025 SHALL drive every archi_X_dnxt field that is not being updated equal to archi_X_qout, and both reset vectors all-zero, whenever no commit occurs.
REQ-026 SHALL commit at most one entry per cycle, in strict program (FIFO) order.
- A non-ready head SHALL block all younger entries.
REQ-027 SHALL allow push and commit in the same cycle.
- Applies when full: the commit frees a slot, but push_ready still reflects the pre-commit full state, so no push.
- Applies when empty: the pushed entry is not committable until the next cycle.
REQ-028 SHALL give flush priority: when flush is high,
- both pointers reset to 0 next cycle;
- commit_valid = 0;
- no outputs are released;
- no push is accepted.
REQ-029 SHALL increment retire_cnt by 1 on every cycle with commit_valid = 1 and wrap at 2^64.
- flush SHALL NOT clear retire_cnt.
REQ-030 SHALL make commit_valid, archi_X_dnxt and both reset vectors combinational from state plus the wbLog_qout, archi_X_qout and flush inputs (zero-cycle commit latency once ready).

Reset
REQ-031 While RSTn is low, SHALL asynchronously clear both pointers, all FIFO entries and retire_cnt.
REQ-032 After reset:
- push_ready = 1.
- commit_valid = 0.
- Both reset vectors are zero.
- archi_X_dnxt equals archi_X_qout.
REQ-033 SHALL discard the FIFO contents on reset mid-operation, with no commit outputs asserted during reset.

Verification
REQ-034 SHALL pass: push {rd=5, phy=1}; archi_X_qout field 5 = 0; set wbLog bit 21 two cycles later -> commit_valid pulses once in that cycle; field 5 of archi_X_dnxt = 1; rnBufU and wbLog reset bit 20 only; retire_cnt = 1.
REQ-035 SHALL pass: push 8 entries with wbLog all zero -> push_ready = 0 after the 8th push; a 9th push_valid is ignored; set the head's wbLog bit -> one commit and push_ready = 1 next cycle.
REQ-036 SHALL pass: push {rd=3, phy=2} then {rd=4, phy=1}; set wbLog bit 17 only -> no commit (head blocked); then set bit 14 -> consecutive commits for rd=3 then rd=4.
REQ-037 SHALL pass: push {rd=0, phy=3} -> commits the next cycle; archi_X_dnxt equals archi_X_qout; reset vectors zero; retire_cnt increments.
REQ-038 SHALL pass: with 5 entries queued and the head ready, assert flush -> commit_valid = 0 that cycle; FIFO empty next cycle; retire_cnt unchanged.
REQ-039 SHALL pass: drop RSTn mid-stream with 3 entries queued -> empty FIFO immediately; retire_cnt = 0; push_ready = 1 after release.

Source files
------------

// File: rtl/commit_unit.sv
// commit_unit
//   In-order retirement queue sitting between rename and the architectural
//   register map. Rename pushes {rd, phy} pairs; the head retires as soon as
//   its copy has been written back (or it targets x0). On retirement the
//   committed copy pointer of rd moves to phy and the previously committed
//   copy is released in both the rename-buffer and write-back tracking vectors.
//
// Ports
//   CLK, RSTn           clock (rising edge), async active-low reset
//   flush               drop every queued entry, block push and commit
//   push_valid/ready    rename handshake; push_rd/push_phy is the entry
//   wbLog_qout          write-back-done bits, bit RP*X+c = register X copy c
//   archi_X_qout        committed copy pointer per register (RB bits each)
//   archi_X_dnxt        next committed copy pointers
//   rnBufU_commit_rst   one-cycle release pulse for rename-buffer bits
//   wbLog_commit_rst    one-cycle release pulse for write-back bits
//   commit_valid        one instruction retires this cycle
//   retire_cnt          running count of retired instructions
module commit_unit #(
  parameter int RP = 4,
  parameter int RB = 2,
  parameter int DP = 8
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              flush,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [4:0]        push_rd,
  input  logic [RB-1:0]     push_phy,
  input  logic [32*RP-1:0]  wbLog_qout,
  input  logic [RB*32-1:0]  archi_X_qout,
  output logic [RB*32-1:0]  archi_X_dnxt,
  output logic [32*RP-1:0]  rnBufU_commit_rst,
  output logic [32*RP-1:0]  wbLog_commit_rst,
  output logic              commit_valid,
  output logic [63:0]       retire_cnt
);

  localparam int AW = $clog2(DP);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [4:0]    rdMem  [DP];
  logic [RB-1:0] phyMem [DP];
  logic [AW:0]   wrPtr;
  logic [AW:0]   rdPtr;

  logic          empty;
  logic          full;
  logic [4:0]    headRd;
  logic [RB-1:0] headPhy;
  logic          wbHit;
  logic          headReady;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);

  assign push_ready = !full && !flush;

  assign headRd  = rdMem[rdPtr[AW-1:0]];
  assign headPhy = phyMem[rdPtr[AW-1:0]];

  // Write-back lookup for the head's {rd, phy} built as a constant-index mux.
  always_comb begin
    wbHit = 1'b0;
    for (int x = 0; x < 32; x++) begin
      for (int c = 0; c < RP; c++) begin
        if (headRd == 5'(x) && headPhy == RB'(c)) begin
          wbHit = wbLog_qout[RP*x + c];
        end
      end
    end
  end

  assign headReady    = !empty && (headRd == 5'd0 || wbHit);
  assign commit_valid = headReady && !flush;

  // x0 retires silently: no pointer move, nothing released.
  always_comb begin
    archi_X_dnxt      = archi_X_qout;
    rnBufU_commit_rst = '0;
    wbLog_commit_rst  = '0;
    if (commit_valid && headRd != 5'd0) begin
      for (int x = 1; x < 32; x++) begin
        if (headRd == 5'(x)) begin
          archi_X_dnxt[RB*x +: RB] = headPhy;
          for (int c = 0; c < RP; c++) begin
            if (archi_X_qout[RB*x +: RB] == RB'(c)) begin
              rnBufU_commit_rst[RP*x + c] = 1'b1;
              wbLog_commit_rst[RP*x + c]  = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      retire_cnt <= '0;
      for (int i = 0; i < DP; i++) begin
        rdMem[i]  <= '0;
        phyMem[i] <= '0;
      end
    end else begin
      if (flush) begin
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        if (push_valid && push_ready) begin
          rdMem[wrPtr[AW-1:0]]  <= push_rd;
          phyMem[wrPtr[AW-1:0]] <= push_phy;
          wrPtr                 <= wrPtr + PTR_ONE;
        end
        if (commit_valid) begin
          rdPtr <= rdPtr + PTR_ONE;
        end
      end
      // Flush deliberately leaves the retirement count alone.
      if (commit_valid) begin
        retire_cnt <= retire_cnt + 64'd1;
      end
    end
  end

endmodule
